midi_voice_alloc: RTL and testbench
===================================

Name: midi_voice_alloc

Overview:
- Polyphonic voice allocator between midi_ctrl (upstream, clk32 domain) and the synth2 voice bank (downstream).
- Consumes midi_ctrl note_presse/note_release event pulses with note/velocity/channel.
- Assigns each key to one of NUM_VOICES voice slots, with retrigger, free-slot search and oldest-voice stealing.
- Presents registered per-voice gate/note/velocity/trigger buses to the synth.

Parameters:
- NUM_VOICES, 4, number of voice slots; legal range 2..16.
- AGE_W, 4, width of the per-voice age counter; saturates at 2^AGE_W-1.

Ports:
- clk32  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- note_pressed  input  1  one-cycle note-on pulse from midi_ctrl.
- note_released  input  1  one-cycle note-off pulse from midi_ctrl.
- note  input  7  MIDI note number, valid with either pulse.
- velocity  input  7  MIDI velocity, valid with either pulse.
- channel  input  4  MIDI channel, valid with either pulse.
- all_off  input  1  one-cycle all-notes-off pulse.
- voice_gate  output  NUM_VOICES  per-voice key-held flag.
- voice_note  output  7*NUM_VOICES  slot i in bits [7i+6:7i].
- voice_velocity  output  7*NUM_VOICES  slot i in bits [7i+6:7i].
- voice_trig  output  NUM_VOICES  one-cycle pulse when slot i is (re)started.
- voice_steal  output  1  one-cycle pulse when an allocation stole an active slot.
- active_count  output  5  number of slots with gate=1.

Behaviour:
- Reset: on a clk32 edge with rst=1, all outputs are 0, all slot tables (note, velocity, channel, age) are 0, and the pending trig and steal flags are cleared. Reset asserted mid-event discards that event.
- Event priority within one cycle: all_off > note_pressed > note_released. Lower-priority events in the same cycle are dropped.
- Velocity-0 rule: note_pressed with velocity=0 is handled exactly as note_released.
- Latency: every input event is reflected on the outputs on the edge following the cycle in which it is sampled (1-cycle latency). voice_trig and voice_steal are high for exactly that one cycle.
- Allocation sequence on note_pressed with velocity!=0:
  1. Hit: a slot with gate=1, same note and same channel is retriggered. Its velocity is updated, age is set to 0, and voice_trig[i]=1. Ages of other slots are unchanged.
  2. Free slot: otherwise, take the lowest-index slot with gate=0. Load note, velocity and channel, set gate=1, age=0, voice_trig[i]=1. Every other gated slot increments its age, saturating.
  3. Steal: otherwise, take the slot with the largest age; ties go to the lowest index. Load it as in step 2 and additionally pulse voice_steal=1.
- Release (note_released, or note_pressed with velocity=0):
  - Clear the gate of every gated slot whose note and channel match.
  - voice_note and voice_velocity are held so the downstream envelope can play its release.
  - No matching slot means no change and no pulse.
- all_off: all gates go to 0; note, velocity and age values are held; no trig pulse.
- active_count is the registered population count of voice_gate and always matches the voice_gate value visible in the same cycle.
- Age saturation: at 2^AGE_W-1 the age holds its value; no wrap-around.
- Ignored inputs: channel pressure and key pressure are not inputs and have no effect.
- Implementation constraint: selection logic is fully combinational over the slot table, with one registered update per cycle. No back-pressure is needed because midi_ctrl events are at least 3 cycles apart.

Test Plan:
- Reset: rst held 2 cycles, then released → voice_gate=0000, active_count=0, all buses 0, no pulses.
- Fill and steal: note-ons 60, 62, 64, 65 on ch0 at vel 100 → slots 0..3 gated with voice_trig pulses 0001, 0010, 0100, 1000; active_count=4. Fifth note-on 67 → slot 0 (oldest) gets note 67, voice_trig=0001, voice_steal=1.
- Retrigger: note-on 60 ch0 vel 100, then note-on 60 ch0 vel 30 → slot 0 velocity becomes 30, voice_trig=0001, active_count stays 1, slot 1 remains free.
- Release and channel match: note-on 60 on ch0 and ch1 (slots 0 and 1); note-off 60 ch1 → voice_gate=0001, voice_note of slot 1 still 60. Note-on 60 ch1 vel 0 afterwards → no change.
- Collision and all_off: with 3 slots gated, all_off and note_pressed asserted in the same cycle → voice_gate=0000, no voice_trig. Next note-on → slot 0, active_count=1.
- Saturation: with AGE_W=2, hold slot 0 gated while allocating and releasing in other slots more than 3 times → slot 0 age holds at 3, and it is the slot chosen by the next steal.

Source files
------------

// File: rtl/midi_voice_alloc_if.sv
// rtl/midi_voice_alloc_if.sv - note-event inputs and per-voice output buses of the voice allocator
interface midi_voice_alloc_if #(
  parameter int NUM_VOICES = 4
);
  logic                    note_pressed;
  logic                    note_released;
  logic [6:0]              note;
  logic [6:0]              velocity;
  logic [3:0]              channel;
  logic                    all_off;
  logic [NUM_VOICES-1:0]   voice_gate;
  logic [7*NUM_VOICES-1:0] voice_note;
  logic [7*NUM_VOICES-1:0] voice_velocity;
  logic [NUM_VOICES-1:0]   voice_trig;
  logic                    voice_steal;
  logic [4:0]              active_count;

  modport master (
    output note_pressed, note_released, note, velocity, channel, all_off,
    input  voice_gate, voice_note, voice_velocity, voice_trig, voice_steal, active_count
  );

  modport slave (
    input  note_pressed, note_released, note, velocity, channel, all_off,
    output voice_gate, voice_note, voice_velocity, voice_trig, voice_steal, active_count
  );
endinterface

// File: rtl/midi_voice_alloc.sv
// rtl/midi_voice_alloc.sv - polyphonic voice allocator with retrigger, free-slot search and oldest-voice stealing
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic             clk32,
  input  logic             rst,
  midi_voice_alloc_if.slave bus
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  logic [NUM_VOICES-1:0] r_gate;
  logic [6:0]            r_note  [NUM_VOICES];
  logic [6:0]            r_vel   [NUM_VOICES];
  logic [3:0]            r_chan  [NUM_VOICES];
  logic [AGE_W-1:0]      r_age   [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_trig;
  logic                  r_steal;
  logic [4:0]            r_count;

  logic                  w_press_on;
  logic                  w_release;
  logic [NUM_VOICES-1:0] w_match;
  logic                  w_hit_found;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_free_found;
  logic [IDX_W-1:0]      w_free_idx;
  logic [IDX_W-1:0]      w_old_idx;
  logic [AGE_W-1:0]      w_old_age;
  logic [IDX_W-1:0]      w_alloc_idx;

  logic [NUM_VOICES-1:0] w_gate_nx;
  logic [6:0]            w_note_nx [NUM_VOICES];
  logic [6:0]            w_vel_nx  [NUM_VOICES];
  logic [3:0]            w_chan_nx [NUM_VOICES];
  logic [AGE_W-1:0]      w_age_nx  [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_trig_nx;
  logic                  w_steal_nx;
  logic [4:0]            w_count_nx;

  // A velocity-0 note-on is a note-off; priority between event kinds is resolved below.
  assign w_press_on = bus.note_pressed && (bus.velocity != 7'd0);
  assign w_release  = (bus.note_pressed && (bus.velocity == 7'd0)) || bus.note_released;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_match[i] = r_gate[i] && (r_note[i] == bus.note) && (r_chan[i] == bus.channel);
    end
  end

  // Scanning downward lets the lowest matching index win.
  always_comb begin
    w_hit_found  = 1'b0;
    w_hit_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit_found = 1'b1;
        w_hit_idx   = IDX_W'(i);
      end
      if (!r_gate[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // Strict greater-than keeps the lowest index on age ties.
  always_comb begin
    w_old_idx = '0;
    w_old_age = r_age[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (r_age[i] > w_old_age) begin
        w_old_idx = IDX_W'(i);
        w_old_age = r_age[i];
      end
    end
  end

  always_comb begin
    w_gate_nx   = r_gate;
    w_trig_nx   = '0;
    w_steal_nx  = 1'b0;
    w_alloc_idx = w_free_found ? w_free_idx : w_old_idx;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_note_nx[i] = r_note[i];
      w_vel_nx[i]  = r_vel[i];
      w_chan_nx[i] = r_chan[i];
      w_age_nx[i]  = r_age[i];
    end

    if (bus.all_off) begin
      w_gate_nx = '0;
    end else if (w_press_on) begin
      if (w_hit_found) begin
        w_vel_nx[w_hit_idx]  = bus.velocity;
        w_age_nx[w_hit_idx]  = '0;
        w_trig_nx[w_hit_idx] = 1'b1;
      end else begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (r_gate[i] && (IDX_W'(i) != w_alloc_idx) && (r_age[i] != AGE_MAX)) begin
            w_age_nx[i] = r_age[i] + 1'b1;
          end
        end
        w_note_nx[w_alloc_idx] = bus.note;
        w_vel_nx[w_alloc_idx]  = bus.velocity;
        w_chan_nx[w_alloc_idx] = bus.channel;
        w_age_nx[w_alloc_idx]  = '0;
        w_gate_nx[w_alloc_idx] = 1'b1;
        w_trig_nx[w_alloc_idx] = 1'b1;
        w_steal_nx             = !w_free_found;
      end
    end else if (w_release) begin
      w_gate_nx = r_gate & ~w_match;
    end

    w_count_nx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_count_nx = w_count_nx + 5'(w_gate_nx[i]);
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      r_gate  <= '0;
      r_trig  <= '0;
      r_steal <= 1'b0;
      r_count <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_vel[i]  <= '0;
        r_chan[i] <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      r_gate  <= w_gate_nx;
      r_trig  <= w_trig_nx;
      r_steal <= w_steal_nx;
      r_count <= w_count_nx;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= w_note_nx[i];
        r_vel[i]  <= w_vel_nx[i];
        r_chan[i] <= w_chan_nx[i];
        r_age[i]  <= w_age_nx[i];
      end
    end
  end

  assign bus.voice_gate   = r_gate;
  assign bus.voice_trig   = r_trig;
  assign bus.voice_steal  = r_steal;
  assign bus.active_count = r_count;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign bus.voice_note[7*g +: 7]     = r_note[g];
    assign bus.voice_velocity[7*g +: 7] = r_vel[g];
  end
endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb/tb_midi_voice_alloc.sv - randomized and directed checks of midi_voice_alloc against a slot-table model
module tb_midi_voice_alloc;
  localparam int NV   = 4;
  localparam int AW   = 2;
  localparam int AMAX = 3;

  logic clk32 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk32 = ~clk32;

  midi_voice_alloc_if #(.NUM_VOICES(NV)) bus ();

  midi_voice_alloc #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .clk32 (clk32),
    .rst   (rst),
    .bus   (bus)
  );

  bit          m_gate [NV];
  int          m_note [NV];
  int          m_vel  [NV];
  int          m_chan [NV];
  int          m_age  [NV];
  logic [NV-1:0] m_trig;
  bit          m_steal;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] slot_note(input int i);
    return bus.voice_note[7*i +: 7];
  endfunction

  function automatic logic [6:0] slot_vel(input int i);
    return bus.voice_velocity[7*i +: 7];
  endfunction

  // Reference model: applies the event sampled at this edge to the slot table.
  task automatic model_step();
    int hit, tgt, best;
    bit stole;
    m_trig  = '0;
    m_steal = 1'b0;
    if (rst) begin
      for (int i = 0; i < NV; i++) begin
        m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_chan[i] = 0; m_age[i] = 0;
      end
    end else if (bus.all_off) begin
      for (int i = 0; i < NV; i++) m_gate[i] = 0;
    end else if (bus.note_pressed && bus.velocity != 0) begin
      hit = -1;
      for (int i = 0; i < NV; i++)
        if (hit < 0 && m_gate[i] && m_note[i] == int'(bus.note) && m_chan[i] == int'(bus.channel)) hit = i;
      if (hit >= 0) begin
        m_vel[hit] = int'(bus.velocity);
        m_age[hit] = 0;
        m_trig[hit] = 1'b1;
      end else begin
        tgt = -1;
        stole = 0;
        for (int i = 0; i < NV; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
        if (tgt < 0) begin
          stole = 1;
          best = -1;
          for (int i = 0; i < NV; i++) if (m_age[i] > best) begin best = m_age[i]; tgt = i; end
        end
        for (int i = 0; i < NV; i++)
          if (i != tgt && m_gate[i]) m_age[i] = (m_age[i] + 1 > AMAX) ? AMAX : m_age[i] + 1;
        m_gate[tgt] = 1; m_note[tgt] = int'(bus.note); m_vel[tgt] = int'(bus.velocity);
        m_chan[tgt] = int'(bus.channel); m_age[tgt] = 0;
        m_trig[tgt] = 1'b1;
        m_steal = stole;
      end
    end else if (bus.note_pressed || bus.note_released) begin
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && m_note[i] == int'(bus.note) && m_chan[i] == int'(bus.channel)) m_gate[i] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk32);
    model_step();
  end

  logic [NV-1:0] cmp_gate;
  int            cmp_cnt;
  initial forever begin
    @(negedge clk32);
    if (chk_en) begin
      cmp_cnt = 0;
      for (int i = 0; i < NV; i++) begin
        cmp_gate[i] = m_gate[i];
        cmp_cnt += int'(m_gate[i]);
      end
      check("gate", 32'(bus.voice_gate), 32'(cmp_gate));
      check("active_count", 32'(bus.active_count), cmp_cnt);
      check("trig", 32'(bus.voice_trig), 32'(m_trig));
      check("steal", 32'(bus.voice_steal), 32'(m_steal));
      for (int i = 0; i < NV; i++) begin
        check($sformatf("note%0d", i), 32'(slot_note(i)), m_note[i]);
        check($sformatf("vel%0d", i), 32'(slot_vel(i)), m_vel[i]);
      end
    end
  end

  task automatic drive(input bit p, input bit r, input bit a,
                       input logic [6:0] n, input logic [6:0] v, input logic [3:0] c);
    bus.note_pressed  = p;
    bus.note_released = r;
    bus.all_off       = a;
    bus.note          = n;
    bus.velocity      = v;
    bus.channel       = c;
    @(posedge clk32);
    #1;
    bus.note_pressed  = 1'b0;
    bus.note_released = 1'b0;
    bus.all_off       = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic on(input logic [6:0] n, input logic [6:0] v, input logic [3:0] c);
    drive(1'b1, 1'b0, 1'b0, n, v, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    int fill_notes [4];
    int r;
    logic [6:0] rn, rv;
    logic [3:0] rc;
    fill_notes = '{60, 62, 64, 65};
    bus.note_pressed = 1'b0; bus.note_released = 1'b0; bus.all_off = 1'b0;
    bus.note = '0; bus.velocity = '0; bus.channel = '0;

    @(posedge clk32); #1;
    chk_en = 1'b1;
    @(posedge clk32); #1;
    rst = 1'b0;
    check("rst_gate", 32'(bus.voice_gate), 0);
    check("rst_count", 32'(bus.active_count), 0);
    check("rst_notes", 32'(bus.voice_note), 0);
    check("rst_trig", 32'(bus.voice_trig), 0);
    idle(1);
    check("rst_steal", 32'(bus.voice_steal), 0);

    for (int k = 0; k < 4; k++) begin
      on(7'(fill_notes[k]), 7'd100, 4'd0);
      check($sformatf("fill_trig%0d", k), 32'(bus.voice_trig), 32'(1) << k);
      idle(2);
    end
    check("fill_count", 32'(bus.active_count), 4);
    check("fill_gate", 32'(bus.voice_gate), 32'hf);
    on(7'd67, 7'd100, 4'd0);
    check("steal_trig", 32'(bus.voice_trig), 1);
    check("steal_pulse", 32'(bus.voice_steal), 1);
    check("steal_note0", 32'(slot_note(0)), 67);
    idle(1);
    check("steal_one_cycle", 32'(bus.voice_steal), 0);
    idle(1);

    do_reset();
    on(7'd60, 7'd100, 4'd0); idle(2);
    on(7'd60, 7'd30, 4'd0);
    check("retrig_vel", 32'(slot_vel(0)), 30);
    check("retrig_trig", 32'(bus.voice_trig), 1);
    check("retrig_count", 32'(bus.active_count), 1);
    check("retrig_gate", 32'(bus.voice_gate), 1);
    idle(2);

    do_reset();
    on(7'd60, 7'd100, 4'd0); idle(2);
    on(7'd60, 7'd100, 4'd1); idle(2);
    drive(1'b0, 1'b1, 1'b0, 7'd60, 7'd0, 4'd1);
    check("rel_gate", 32'(bus.voice_gate), 1);
    check("rel_note_held", 32'(slot_note(1)), 60);
    idle(2);
    on(7'd60, 7'd0, 4'd1);
    check("vel0_gate", 32'(bus.voice_gate), 1);
    check("vel0_trig", 32'(bus.voice_trig), 0);
    idle(2);

    do_reset();
    on(7'd50, 7'd90, 4'd2); idle(2);
    on(7'd52, 7'd90, 4'd2); idle(2);
    on(7'd54, 7'd90, 4'd2); idle(2);
    drive(1'b1, 1'b0, 1'b1, 7'd70, 7'd100, 4'd0);
    check("alloff_gate", 32'(bus.voice_gate), 0);
    check("alloff_trig", 32'(bus.voice_trig), 0);
    idle(2);
    on(7'd71, 7'd100, 4'd0);
    check("after_off_trig", 32'(bus.voice_trig), 1);
    check("after_off_count", 32'(bus.active_count), 1);
    idle(2);

    do_reset();
    on(7'd40, 7'd100, 4'd0); idle(2);
    repeat (5) begin
      on(7'd41, 7'd100, 4'd0); idle(2);
      drive(1'b0, 1'b1, 1'b0, 7'd41, 7'd0, 4'd0); idle(2);
    end
    on(7'd70, 7'd100, 4'd0); idle(2);
    on(7'd71, 7'd100, 4'd0); idle(2);
    on(7'd72, 7'd100, 4'd0); idle(2);
    on(7'd73, 7'd100, 4'd0);
    check("sat_steal_trig", 32'(bus.voice_trig), 1);
    check("sat_steal_pulse", 32'(bus.voice_steal), 1);
    idle(2);

    do_reset();
    repeat (600) begin
      r  = int'($urandom_range(0, 99));
      rn = 7'(60 + $urandom_range(0, 5));
      rc = 4'($urandom_range(0, 1));
      rv = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      if (r == 95) rst = 1'b1;
      drive(r < 55, (r >= 40) && (r < 90), r >= 96, rn, rv, rc);
      rst = 1'b0;
      idle(2 + int'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
